// File: rtl/dp_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dp_ctrl_pkg
// Shared types and encodings for the datapath sequencing controller.
//   state_t   : controller FSM states
//   iclass_t  : decoded instruction class used by the FSM
//   OPC_*/OP_*: opcode (IR[15:13]) and op (IR[12:11]) encodings
//   ALU_*     : aluop encodings driven to the datapath ALU
//   VSEL_*    : register-file write-source select encodings
//   classify(): maps opcode/op to an instruction class (illegal if unknown)
// -----------------------------------------------------------------------------
package dp_ctrl_pkg;

    typedef enum logic [2:0] {
        S_WAIT    = 3'd0,
        S_LOAD_AB = 3'd1,
        S_EXEC    = 3'd2,
        S_WB      = 3'd3,
        S_WR_IMM  = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        IC_ILLEGAL = 2'd0,
        IC_MOV_IMM = 2'd1,
        IC_MOV_REG = 2'd2,
        IC_ALU     = 2'd3
    } iclass_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_AND    = 2'b10;
    localparam logic [1:0] ALU_NOTB   = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM8  = 2'b01;
    localparam logic [1:0] VSEL_PC    = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    // Every op value under OPC_ALU is legal; under OPC_MOV only the
    // immediate and register forms exist.
    function automatic iclass_t classify(input logic [2:0] opcode,
                                         input logic [1:0] op);
        iclass_t ic;
        ic = IC_ILLEGAL;
        if (opcode == OPC_ALU) begin
            ic = IC_ALU;
        end else if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM) begin
                ic = IC_MOV_IMM;
            end else if (op == OP_MOV_REG) begin
                ic = IC_MOV_REG;
            end
        end
        return ic;
    endfunction

endpackage

// File: rtl/dp_ctrl_fsm_instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
// Purely combinational split of a 16-bit instruction into its fields, plus
// sign-extended immediates and the instruction class.
// Parameters:
//   WIDTH     : width of the sign-extended immediates (>= 8)
// Ports:
//   i_ir      in  16     instruction word
//   o_op      out 2      IR[12:11]
//   o_rn      out 3      IR[10:8]
//   o_rd      out 3      IR[7:5]
//   o_sh      out 2      IR[4:3]
//   o_rm      out 3      IR[2:0]
//   o_iclass  out        instruction class (IC_ILLEGAL when not decodable)
//   o_sximm5  out WIDTH  sign-extended IR[4:0]
//   o_sximm8  out WIDTH  sign-extended IR[7:0]
// -----------------------------------------------------------------------------
module instr_decode
    import dp_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [15:0]      i_ir,
    output logic [1:0]       o_op,
    output logic [2:0]       o_rn,
    output logic [2:0]       o_rd,
    output logic [1:0]       o_sh,
    output logic [2:0]       o_rm,
    output iclass_t          o_iclass,
    output logic [WIDTH-1:0] o_sximm5,
    output logic [WIDTH-1:0] o_sximm8
);

    assign o_op     = i_ir[12:11];
    assign o_rn     = i_ir[10:8];
    assign o_rd     = i_ir[7:5];
    assign o_sh     = i_ir[4:3];
    assign o_rm     = i_ir[2:0];
    assign o_iclass = classify(i_ir[15:13], i_ir[12:11]);

    assign o_sximm5[4:0] = i_ir[4:0];
    assign o_sximm8[7:0] = i_ir[7:0];

    genvar gi;
    generate
        for (gi = 5; gi < WIDTH; gi++) begin : g_sx5
            assign o_sximm5[gi] = i_ir[4];
        end
        for (gi = 8; gi < WIDTH; gi++) begin : g_sx8
            assign o_sximm8[gi] = i_ir[7];
        end
    endgenerate

endmodule

// File: rtl/dp_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// dp_ctrl_fsm
// Sequencing controller for the register/ALU datapath. Accepts one
// instruction per start handshake (s=1 while w=1), latches it into IR and
// walks WAIT -> {WR_IMM | LOAD_AB -> EXEC [-> WB]} -> WAIT, driving every
// datapath control as a Moore function of state and IR.
// Build option:
//   DP_CTRL_TRAP_EN  defined : an illegal instruction on accept enters HALT
//                              (w=0, err=1) until reset.
//                    undefined: an illegal instruction is a NOP, err tied 0.
// Parameters:
//   WIDTH  datapath word width (sximm5/sximm8 width)
//   SIZE   register count; register addresses are $clog2(SIZE) bits
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   s, instr             start strobe and instruction (sampled on accept)
//   w, err               ready (WAIT only), illegal-instruction trap flag
//   vsel, writenum, write                regfile write controls
//   readnum1, readnum2, loada, loadb     operand fetch controls
//   asel, bsel, shift, aluop, loadc, loads  execute controls
//   sximm5, sximm8       sign-extended immediates from IR
// -----------------------------------------------------------------------------
module dp_ctrl_fsm
    import dp_ctrl_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int SIZE       = 8,
    localparam int ADDR_WIDTH = $clog2(SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s,
    input  logic [15:0]           instr,
    output logic                  w,
    output logic                  err,
    output logic [1:0]            vsel,
    output logic [ADDR_WIDTH-1:0] writenum,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] readnum1,
    output logic [ADDR_WIDTH-1:0] readnum2,
    output logic                  loada,
    output logic                  loadb,
    output logic                  asel,
    output logic                  bsel,
    output logic [1:0]            shift,
    output logic [1:0]            aluop,
    output logic                  loadc,
    output logic                  loads,
    output logic [WIDTH-1:0]      sximm5,
    output logic [WIDTH-1:0]      sximm8
);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_ir;

    logic [1:0]  w_op;
    logic [2:0]  w_rn;
    logic [2:0]  w_rd;
    logic [1:0]  w_sh;
    logic [2:0]  w_rm;
    iclass_t     w_iclass;
    iclass_t     w_in_class;
    logic        w_accept;
    logic        w_is_cmp;

    instr_decode #(
        .WIDTH    (WIDTH)
    ) u_decode (
        .i_ir     (r_ir),
        .o_op     (w_op),
        .o_rn     (w_rn),
        .o_rd     (w_rd),
        .o_sh     (w_sh),
        .o_rm     (w_rm),
        .o_iclass (w_iclass),
        .o_sximm5 (sximm5),
        .o_sximm8 (sximm8)
    );

    // The branch out of WAIT is decided on the incoming word, since IR only
    // captures it on the same edge.
    assign w_in_class = classify(instr[15:13], instr[12:11]);
    assign w_accept   = (r_state == S_WAIT) && s;
    assign w_is_cmp   = (w_iclass == IC_ALU) && (w_op == OP_CMP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_ir <= instr;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w            = 1'b0;
        err          = 1'b0;
        vsel         = VSEL_C;
        writenum     = '0;
        write        = 1'b0;
        readnum1     = '0;
        readnum2     = '0;
        loada        = 1'b0;
        loadb        = 1'b0;
        asel         = 1'b0;
        bsel         = 1'b0;
        shift        = 2'b00;
        aluop        = ALU_ADD;
        loadc        = 1'b0;
        loads        = 1'b0;

        case (r_state)
            S_WAIT: begin
                w = 1'b1;
                if (s) begin
                    case (w_in_class)
                        IC_MOV_IMM: w_state_next = S_WR_IMM;
                        IC_MOV_REG,
                        IC_ALU:     w_state_next = S_LOAD_AB;
                        default: begin
`ifdef DP_CTRL_TRAP_EN
                            w_state_next = S_HALT;
`else
                            w_state_next = S_WAIT;
`endif
                        end
                    endcase
                end
            end
            S_WR_IMM: begin
                vsel         = VSEL_IMM8;
                writenum     = ADDR_WIDTH'(w_rn);
                write        = 1'b1;
                w_state_next = S_WAIT;
            end
            S_LOAD_AB: begin
                readnum1     = ADDR_WIDTH'(w_rn);
                readnum2     = ADDR_WIDTH'(w_rm);
                loada        = 1'b1;
                loadb        = 1'b1;
                w_state_next = S_EXEC;
            end
            S_EXEC: begin
                bsel  = 1'b1;
                shift = w_sh;
                // MOV reg routes the shifted Rm through ADD with a zero A input.
                if (w_iclass == IC_MOV_REG) begin
                    asel  = 1'b0;
                    aluop = ALU_ADD;
                end else begin
                    asel  = 1'b1;
                    aluop = w_op;
                end
                loadc        = !w_is_cmp;
                loads        = w_is_cmp;
                w_state_next = w_is_cmp ? S_WAIT : S_WB;
            end
            S_WB: begin
                vsel         = VSEL_C;
                writenum     = ADDR_WIDTH'(w_rd);
                write        = 1'b1;
                w_state_next = S_WAIT;
            end
            S_HALT: begin
`ifdef DP_CTRL_TRAP_EN
                err = 1'b1;
`endif
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_dp_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_dp_ctrl_fsm
// Self-checking bench for dp_ctrl_fsm. For each issued instruction the
// expected per-cycle control vectors are pushed to a queue; a monitor pops
// and compares one entry for every busy cycle. A small behavioural datapath
// driven by the DUT controls checks end results in the register file.
// Build with +define+DP_CTRL_TRAP_EN to exercise the trap variant.
// -----------------------------------------------------------------------------
module tb_dp_ctrl_fsm;

    logic        clk;
    logic        reset;
    logic        s;
    logic [15:0] instr;
    logic        w;
    logic        err;
    logic [1:0]  vsel;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readnum1;
    logic [2:0]  readnum2;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic        loadc;
    logic        loads;
    logic [15:0] sximm5;
    logic [15:0] sximm8;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        mon_en   = 1'b0;
    logic [54:0] q_exp[$];

    dp_ctrl_fsm #(
        .WIDTH    (16),
        .SIZE     (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s        (s),
        .instr    (instr),
        .w        (w),
        .err      (err),
        .vsel     (vsel),
        .writenum (writenum),
        .write    (write),
        .readnum1 (readnum1),
        .readnum2 (readnum2),
        .loada    (loada),
        .loadb    (loadb),
        .asel     (asel),
        .bsel     (bsel),
        .shift    (shift),
        .aluop    (aluop),
        .loadc    (loadc),
        .loads    (loads),
        .sximm5   (sximm5),
        .sximm8   (sximm8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [22:0] ctrl_vec();
        return {err, vsel, writenum, write, readnum1, readnum2, loada, loadb,
                asel, bsel, shift, aluop, loadc, loads};
    endfunction

    function automatic logic [54:0] dut_vec();
        return {ctrl_vec(), sximm5, sximm8};
    endfunction

    function automatic logic [54:0] mk(input logic [1:0] vs, input logic [2:0] wn,
                                       input logic wr, input logic [2:0] r1,
                                       input logic [2:0] r2, input logic la,
                                       input logic lb, input logic as,
                                       input logic bs, input logic [1:0] sh,
                                       input logic [1:0] alu, input logic lc,
                                       input logic ls, input logic [15:0] ins);
        logic [15:0] s5;
        logic [15:0] s8;
        s5 = {{11{ins[4]}}, ins[4:0]};
        s8 = {{8{ins[7]}}, ins[7:0]};
        return {1'b0, vs, wn, wr, r1, r2, la, lb, as, bs, sh, alu, lc, ls, s5, s8};
    endfunction

    // Expected busy-cycle control vectors for one accepted instruction.
    task automatic push_model(input logic [15:0] ins);
        logic [2:0] opc;
        logic [1:0] op;
        logic       mov;
        logic       cmp;
        opc = ins[15:13];
        op  = ins[12:11];
        if (opc == 3'b110 && op == 2'b10) begin
            q_exp.push_back(mk(2'b01, ins[10:8], 1'b1, 3'd0, 3'd0, 1'b0, 1'b0,
                               1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, ins));
        end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
            mov = (opc == 3'b110);
            cmp = (opc == 3'b101) && (op == 2'b01);
            q_exp.push_back(mk(2'b00, 3'd0, 1'b0, ins[10:8], ins[2:0], 1'b1, 1'b1,
                               1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, ins));
            q_exp.push_back(mk(2'b00, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0,
                               !mov, 1'b1, ins[4:3], mov ? 2'b00 : op, !cmp, cmp, ins));
            if (!cmp) begin
                q_exp.push_back(mk(2'b00, ins[7:5], 1'b1, 3'd0, 3'd0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, ins));
            end
        end
    endtask

    // Monitor: one queue entry per busy cycle; all controls idle while ready.
    always @(posedge clk) begin
        #1;
        if (mon_en && !reset) begin
            if (w == 1'b0) begin
                if (q_exp.size() == 0) begin
                    chk("q_underflow", 64'(q_exp.size()), 64'd1);
                end else begin
                    chk("busy_ctrl", 64'(dut_vec()), 64'(q_exp.pop_front()));
                end
            end else begin
                chk("idle_ctrl", 64'(ctrl_vec()), 64'd0);
            end
        end
    end

    // Behavioural datapath: regfile, A/B/C, shifter, ALU, Z flag.
    logic [15:0] rf [8];
    logic [15:0] ra;
    logic [15:0] rb;
    logic [15:0] rc;
    logic        rz;

    always @(posedge clk) begin : dp_model
        logic [15:0] shb;
        logic [15:0] ain;
        logic [15:0] bin;
        logic [15:0] alu;
        case (shift)
            2'b00:   shb = rb;
            2'b01:   shb = rb << 1;
            2'b10:   shb = rb >> 1;
            default: shb = {rb[15], rb[15:1]};
        endcase
        ain = asel ? ra : 16'h0;
        bin = bsel ? shb : sximm5;
        case (aluop)
            2'b00:   alu = ain + bin;
            2'b01:   alu = ain - bin;
            2'b10:   alu = ain & bin;
            default: alu = ~bin;
        endcase
        if (write) rf[writenum] <= (vsel == 2'b00) ? rc : (vsel == 2'b01) ? sximm8 : 16'h0;
        if (loada) ra <= rf[readnum1];
        if (loadb) rb <= rf[readnum2];
        if (loadc) rc <= alu;
        if (loads) rz <= (alu == 16'h0);
    end

    task automatic run(input logic [15:0] ins, input int exp_busy, input string tag);
        int busy;
        @(negedge clk);
        s     = 1'b1;
        instr = ins;
        push_model(ins);
        @(negedge clk);
        s     = 1'b0;
        instr = 16'($urandom);
        busy  = 0;
        while (w == 1'b0 && busy < 20) begin
            busy++;
            @(negedge clk);
        end
        chk({tag, "_busy"}, 64'(busy), 64'(exp_busy));
        chk({tag, "_qempty"}, 64'(q_exp.size()), 64'd0);
        $display("txn %s instr=%h busy=%0d", tag, ins, busy);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        s     = 1'b0;
        instr = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_w", 64'(w), 64'd1);
        chk("rst_ctrl", 64'(ctrl_vec()), 64'd0);
        chk("rst_sximm", 64'({sximm5, sximm8}), 64'd0);
        mon_en = 1'b1;

        run(16'hD0FD, 1, "mov_r0_m3");
        chk("r0", 64'(rf[0]), 64'hFFFD);
        run(16'hD107, 1, "mov_r1_7");
        run(16'hD202, 1, "mov_r2_2");
        run(16'hA16A, 3, "add_r3_lsl");
        chk("r3_add", 64'(rf[3]), 64'd11);
        run(16'hA901, 2, "cmp_r1_r1");
        chk("z_cmp", 64'(rz), 64'd1);
        run(16'hC091, 3, "mov_r4_lsr");
        chk("r4_mov", 64'(rf[4]), 64'd3);
        run(16'hB8A2, 3, "mvn_r5");
        chk("r5_mvn", 64'(rf[5]), 64'hFFFD);
        run(16'hB1C2, 3, "and_r6");
        chk("r6_and", 64'(rf[6]), 64'd2);

        // Back-to-back accept with s held; noise on s/instr while busy.
        @(negedge clk);
        s = 1'b1; instr = 16'hD709; push_model(16'hD709);
        @(negedge clk);
        chk("b2b_busy1", 64'(w), 64'd0);
        instr = 16'hD7FF;
        @(negedge clk);
        chk("b2b_ready", 64'(w), 64'd1);
        instr = 16'hA7E7; push_model(16'hA7E7);
        @(negedge clk);
        chk("b2b_second_accept", 64'(w), 64'd0);
        n = 0;
        while (w == 1'b0 && n < 20) begin
            s     = (n % 2 == 0);
            instr = 16'hD7FF;
            n++;
            @(negedge clk);
        end
        s = 1'b0;
        chk("b2b_add_busy", 64'(n), 64'd3);
        chk("b2b_qempty", 64'(q_exp.size()), 64'd0);
        chk("r7_b2b", 64'(rf[7]), 64'd18);
        $display("txn b2b instr=D709,A7E7 busy=%0d", n);

        // Reset held for two edges while ADD sits in EXEC.
        run(16'hD305, 1, "mov_r3_5");
        mon_en = 1'b0;
        @(negedge clk);
        s = 1'b1; instr = 16'hA16A;
        @(negedge clk);
        s = 1'b0;
        chk("abort_loadab", 64'(loada), 64'd1);
        @(negedge clk);
        chk("abort_exec", 64'(loadc), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_w", 64'(w), 64'd1);
        chk("abort_write", 64'(write), 64'd0);
        s = 1'b1; instr = 16'hD3FF;
        @(negedge clk);
        reset = 1'b0; s = 1'b0;
        chk("rst_beats_s", 64'(w), 64'd1);
        chk("abort_ctrl", 64'(ctrl_vec()), 64'd0);
        @(negedge clk);
        chk("abort_r3", 64'(rf[3]), 64'd5);
        q_exp.delete();
        $display("txn reset_abort instr=A16A");
        mon_en = 1'b1;

        // Illegal instruction.
`ifdef DP_CTRL_TRAP_EN
        mon_en = 1'b0;
        @(negedge clk);
        s = 1'b1; instr = 16'hE000;
        @(negedge clk);
        s = 1'b0;
        repeat (3) begin
            chk("trap_w", 64'(w), 64'd0);
            chk("trap_err", 64'(err), 64'd1);
            chk("trap_ctrl", 64'(ctrl_vec() & 23'h3FFFFF), 64'd0);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("trap_clear_w", 64'(w), 64'd1);
        chk("trap_clear_err", 64'(err), 64'd0);
        $display("txn illegal_trap instr=E000");
        mon_en = 1'b1;
`else
        run(16'hE000, 0, "illegal_nop");
        repeat (2) begin
            chk("nop_err", 64'(err), 64'd0);
            chk("nop_w", 64'(w), 64'd1);
            @(negedge clk);
        end
`endif
        run(16'hD705, 1, "mov_r7_5");
        chk("r7_after", 64'(rf[7]), 64'd5);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
